// File: rtl/pio_shift_engine.sv
// ISR/OSR shift datapath behind PIO IN/OUT/PUSH/PULL with autopush/autopull and FIFO stalls.
// Optional stall_cycles counter output is built when PIO_SHIFT_STALL_CNT_EN is defined.
module pio_shift_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic              restart,
  input  logic              shift_dir,
  input  logic              auto_push,
  input  logic              auto_pull,
  input  logic [CNT_W-1:0]  isr_threshold,
  input  logic [CNT_W-1:0]  osr_threshold,
  input  logic              in_en,
  input  logic [CNT_W-1:0]  in_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_en,
  input  logic [CNT_W-1:0]  out_count,
  input  logic              push_req,
  input  logic              pull_req,
  input  logic              block,
  input  logic [DATA_W-1:0] x_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] isr,
  output logic [DATA_W-1:0] osr,
  output logic              stall,
`ifdef PIO_SHIFT_STALL_CNT_EN
  output logic [15:0]       stall_cycles,
`endif
  output logic              rx_drop
);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StPushWait,
    StPullWait,
    StPullOut,
    StOutExec
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  isr_q, isr_d;
  logic [DATA_W-1:0]  osr_q, osr_d;
  logic [CNT_W-1:0]   isr_cnt_q, isr_cnt_d;
  logic [CNT_W-1:0]   osr_cnt_q, osr_cnt_d;
  logic [CNT_W-1:0]   out_n_q, out_n_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               rx_drop_q, rx_drop_d;
  logic               rx_valid_c, tx_ready_c;
  logic               do_out;
  logic [CNT_W-1:0]   out_amt;
  logic [CNT_W-1:0]   in_n;
  logic [CNT_W-1:0]   isr_thr, osr_thr;
  logic [CNT_W-1:0]   isr_cnt_next;
  logic [DATA_W-1:0]  isr_shifted;

  // A count of zero, or anything beyond the word width, selects a full word.
  function automatic logic [CNT_W-1:0] eff_cnt(input logic [CNT_W-1:0] c);
    return ((c == '0) || (c > FullCnt)) ? FullCnt : c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, FullCnt}) ? FullCnt : s[CNT_W-1:0];
  endfunction

  always_comb begin
    in_n         = eff_cnt(in_count);
    isr_thr      = eff_cnt(isr_threshold);
    osr_thr      = eff_cnt(osr_threshold);
    isr_cnt_next = sat_add(isr_cnt_q, in_n);
    // Shifting by a full word yields zero, so the n == DATA_W case needs no special path.
    if (shift_dir) begin
      isr_shifted = (isr_q << in_n) | (in_data & ~({DATA_W{1'b1}} << in_n));
    end else begin
      isr_shifted = (isr_q >> in_n) | (in_data << (FullCnt - in_n));
    end
  end

  always_comb begin
    state_d     = state_q;
    isr_d       = isr_q;
    osr_d       = osr_q;
    isr_cnt_d   = isr_cnt_q;
    osr_cnt_d   = osr_cnt_q;
    out_n_d     = out_n_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    rx_drop_d   = 1'b0;
    rx_valid_c  = 1'b0;
    tx_ready_c  = 1'b0;
    do_out      = 1'b0;
    out_amt     = out_n_q;

    if (penable) begin
      unique case (state_q)
        StIdle: begin
          if (pull_req) begin
            if (!(auto_pull && (osr_cnt_q < osr_thr))) begin
              if (tx_valid) begin
                tx_ready_c = 1'b1;
                osr_d      = tx_data;
                osr_cnt_d  = '0;
              end else if (block) begin
                state_d = StPullWait;
              end else begin
                osr_d     = x_in;
                osr_cnt_d = '0;
              end
            end
          end else if (push_req) begin
            rx_valid_c = 1'b1;
            if (rx_ready) begin
              isr_d     = '0;
              isr_cnt_d = '0;
            end else if (block) begin
              state_d = StPushWait;
            end else begin
              isr_d     = '0;
              isr_cnt_d = '0;
              rx_drop_d = 1'b1;
            end
          end else if (out_en) begin
            if (auto_pull && (osr_cnt_q >= osr_thr)) begin
              state_d = StPullOut;
              out_n_d = eff_cnt(out_count);
            end else begin
              do_out  = 1'b1;
              out_amt = eff_cnt(out_count);
            end
          end else if (in_en) begin
            isr_d     = isr_shifted;
            isr_cnt_d = isr_cnt_next;
            if (auto_push && (isr_cnt_next >= isr_thr)) begin
              state_d = StPushWait;
            end
          end
        end
        StPushWait: begin
          rx_valid_c = 1'b1;
          if (rx_ready) begin
            isr_d     = '0;
            isr_cnt_d = '0;
            state_d   = StIdle;
          end
        end
        StPullWait, StPullOut: begin
          tx_ready_c = tx_valid;
          if (tx_valid) begin
            osr_d     = tx_data;
            osr_cnt_d = '0;
            state_d   = (state_q == StPullOut) ? StOutExec : StIdle;
          end
        end
        StOutExec: begin
          do_out  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase

      if (do_out) begin
        out_valid_d = 1'b1;
        osr_cnt_d   = sat_add(osr_cnt_q, out_amt);
        if (shift_dir) begin
          out_data_d = osr_q >> (FullCnt - out_amt);
          osr_d      = osr_q << out_amt;
        end else begin
          out_data_d = osr_q & ~({DATA_W{1'b1}} << out_amt);
          osr_d      = osr_q >> out_amt;
        end
      end
    end

    if (restart) begin
      state_d     = StIdle;
      isr_d       = '0;
      osr_d       = '0;
      isr_cnt_d   = '0;
      osr_cnt_d   = FullCnt;
      out_n_d     = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      rx_drop_d   = 1'b0;
      rx_valid_c  = 1'b0;
      tx_ready_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      isr_q       <= '0;
      osr_q       <= '0;
      isr_cnt_q   <= '0;
      osr_cnt_q   <= FullCnt;
      out_n_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      isr_q       <= isr_d;
      osr_q       <= osr_d;
      isr_cnt_q   <= isr_cnt_d;
      osr_cnt_q   <= osr_cnt_d;
      out_n_q     <= out_n_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

`ifdef PIO_SHIFT_STALL_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (restart) begin
      stall_cycles_d = '0;
    end else if (penable && stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

  // Handshakes are masked during reset so every output reads zero while it is held.
  assign rx_valid  = rx_valid_c & ~reset;
  assign tx_ready  = tx_ready_c & ~reset;
  assign rx_data   = isr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign isr       = isr_q;
  assign osr       = osr_q;
  assign stall     = (state_q != StIdle);
  assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_pio_shift_engine.sv
// Directed bench for pio_shift_engine (DATA_W=32) with hand-computed expected values.
module tb_pio_shift_engine;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;

  logic              clk = 1'b0;
  logic              reset, penable, restart, shift_dir, auto_push, auto_pull;
  logic [CNT_W-1:0]  isr_threshold, osr_threshold, in_count, out_count;
  logic              in_en, out_en, push_req, pull_req, block;
  logic [DATA_W-1:0] in_data, x_in, tx_data;
  logic [DATA_W-1:0] rx_data, out_data, isr, osr;
  logic              rx_valid, rx_ready, tx_valid, tx_ready, out_valid, stall, rx_drop;
`ifdef PIO_SHIFT_STALL_CNT_EN
  logic [15:0]       stall_cycles;
`endif

  int total = 0;
  int bad   = 0;
  int n_stall, n_drop;
  logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  pio_shift_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .penable(penable), .restart(restart),
    .shift_dir(shift_dir), .auto_push(auto_push), .auto_pull(auto_pull),
    .isr_threshold(isr_threshold), .osr_threshold(osr_threshold),
    .in_en(in_en), .in_count(in_count), .in_data(in_data),
    .out_en(out_en), .out_count(out_count), .push_req(push_req), .pull_req(pull_req),
    .block(block), .x_in(x_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .out_data(out_data), .out_valid(out_valid), .isr(isr), .osr(osr), .stall(stall),
`ifdef PIO_SHIFT_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; penable = 1'b1; restart = 1'b0; shift_dir = 1'b0;
    auto_push = 1'b0; auto_pull = 1'b0; isr_threshold = '0; osr_threshold = '0;
    in_en = 1'b0; in_count = '0; in_data = '0; out_en = 1'b0; out_count = '0;
    push_req = 1'b0; pull_req = 1'b0; block = 1'b0; x_in = '0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
    #1;
    check("rst_isr", isr, 0);
    check("rst_osr", osr, 0);
    check("rst_stall", stall, 0);
    check("rst_outv", out_valid, 0);
    check("rst_osr_cnt", dut.osr_cnt_q, 32);
    #12 reset = 1'b0;
    step();

    // Right-shift IN 8 x4 with autopush at full word.
    auto_push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_en = 1'b1; in_count = 6'd8; in_data = {24'h0, bytes[i]};
      step();
      in_en = 1'b0;
      if (i == 2) begin
        check("in3_isr", isr, 32'h33221100);
        check("in3_no_push", rx_valid, 0);
      end
    end
    check("apush_stall", stall, 1);
    check("apush_valid", rx_valid, 1);
    check("apush_data", rx_data, 32'h44332211);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("apush_isr_clr", isr, 0);
    check("apush_idle", stall, 0);
    check("apush_cnt", dut.isr_cnt_q, 0);

    // Left PULL then OUT 4 twice.
    auto_push = 1'b0; shift_dir = 1'b1;
    pull_req = 1'b1; tx_valid = 1'b1; tx_data = 32'hA500_0000;
    #1 check("pull_txr", tx_ready, 1);
    step();
    pull_req = 1'b0; tx_valid = 1'b0;
    check("pull_osr", osr, 32'hA500_0000);
    out_en = 1'b1; out_count = 6'd4;
    step();
    check("outl1_v", out_valid, 1);
    check("outl1_d", out_data, 32'hA);
    step();
    out_en = 1'b0;
    check("outl2_d", out_data, 32'h5);
    check("outl2_osr", osr, 0);
    check("outl2_cnt", dut.osr_cnt_q, 8);
    step();
    check("outv_pulse", out_valid, 0);

    // Autopull stall, threshold 16, right shift.
    shift_dir = 1'b0;
    pull_req = 1'b1; tx_valid = 1'b1; tx_data = 32'h1234_5678;
    step();
    pull_req = 1'b0; tx_valid = 1'b0;
    auto_pull = 1'b1; osr_threshold = 6'd16;
    out_en = 1'b1; out_count = 6'd16;
    step();
    check("out16_d", out_data, 32'h5678);
    check("out16_cnt", dut.osr_cnt_q, 16);
    out_count = 6'd8;
    step();
    check("apull_stall", stall, 1);
    check("apull_nov", out_valid, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("apull_hold", {stall, tx_ready}, 2'b10);
    end
    tx_valid = 1'b1; tx_data = 32'hCAFE_BABE;
    #1 check("apull_txr", tx_ready, 1);
    step();
    tx_valid = 1'b0;
    check("apull_exec_stall", stall, 1);
    step();
    out_en = 1'b0;
    check("apull_outv", out_valid, 1);
    check("apull_outd", out_data, 32'hBE);
    check("apull_idle", stall, 0);
    check("apull_osr", osr, 32'h00CA_FEBA);
    check("apull_cnt", dut.osr_cnt_q, 8);

    // Blocking PUSH held off for 5 cycles.
    auto_pull = 1'b0;
    in_en = 1'b1; in_count = 6'd8; in_data = 32'h5A;
    step();
    in_en = 1'b0;
    push_req = 1'b1; block = 1'b1; rx_ready = 1'b0;
    n_stall = 0; n_drop = 0;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        rx_ready = 1'b1;
        #1 check("bpush_data", rx_data, 32'h5A00_0000);
      end
      if (stall) n_stall++;
      step();
      if (rx_drop) n_drop++;
      push_req = 1'b0;
    end
    rx_ready = 1'b0;
    check("bpush_stalls", n_stall, 5);
    check("bpush_nodrop", n_drop, 0);
    check("bpush_idle", stall, 0);
    check("bpush_isr", isr, 0);

    // Non-blocking PUSH with RX full drops the word.
    block = 1'b0;
    in_en = 1'b1; in_data = 32'h77;
    step();
    in_en = 1'b0; push_req = 1'b1;
    step();
    push_req = 1'b0;
    check("drop_pulse", rx_drop, 1);
    check("drop_isr", isr, 0);
    check("drop_cnt", dut.isr_cnt_q, 0);
    step();
    check("drop_end", rx_drop, 0);

    // penable low freezes state.
    penable = 1'b0; in_en = 1'b1; in_data = 32'hFF;
    step();
    in_en = 1'b0; penable = 1'b1;
    check("freeze_isr", isr, 0);
    check("freeze_cnt", dut.isr_cnt_q, 0);

    // Non-blocking PULL on empty TX loads X.
    x_in = 32'hDEAD_BEEF; pull_req = 1'b1;
    #1 check("xpull_txr", tx_ready, 0);
    step();
    pull_req = 1'b0;
    check("xpull_osr", osr, 32'hDEAD_BEEF);
    check("xpull_cnt", dut.osr_cnt_q, 0);

    // Restart clears even with penable low.
    in_en = 1'b1; in_data = 32'h3C;
    step();
    in_en = 1'b0; restart = 1'b1; penable = 1'b0;
    step();
    restart = 1'b0; penable = 1'b1;
    check("restart_isr", isr, 0);
    check("restart_osr", osr, 0);
    check("restart_cnt", dut.osr_cnt_q, 32);

    // Async reset while in PULL_OUT.
    x_in = 32'h0000_BEEF; pull_req = 1'b1;
    step();
    pull_req = 1'b0; auto_pull = 1'b1; osr_threshold = 6'd16;
    out_en = 1'b1; out_count = 6'd16;
    step();
    check("pre_rst_out", out_data, 32'hBEEF);
    out_count = 6'd8;
    step();
    check("pre_rst_stall", stall, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_stall", stall, 0);
    check("arst_osr", osr, 0);
    check("arst_outd", out_data, 0);
    check("arst_hs", {rx_valid, tx_ready, out_valid, rx_drop}, 0);
    out_en = 1'b0; auto_pull = 1'b0;
    #3 reset = 1'b0;
    step();
    check("arst_osr_cnt", dut.osr_cnt_q, 32);
    check("arst_idle", stall, 0);
`ifdef PIO_SHIFT_STALL_CNT_EN
    check("arst_stall_cycles", stall_cycles, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pio_shift_engine.md
Name: pio_shift_engine

Overview:
Parametrised input/output shift unit for a PIO state machine. It implements the ISR/OSR datapath behind IN, OUT, PUSH and PULL. It adds configurable data width, per-op shift counts, autopush/autopull with thresholds, and blocking FIFO handshakes with stall reporting. It sits between the machine's instruction execution and its RX/TX FIFOs. All register updates are qualified by the machine's divided clock enable.

Parameters:
DATA_W, 32, width of ISR, OSR, FIFO words and shift data (>=8)
CNT_W, $clog2(DATA_W)+1, width of shift counts and thresholds

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
penable  input  1  divided clock enable; state changes only when 1
restart  input  1  synchronous clear of ISR/OSR/counts/FSM (acts regardless of penable)
shift_dir  input  1  0 = shift right, 1 = shift left
auto_push  input  1  autopush enable
auto_pull  input  1  autopull enable
isr_threshold  input  CNT_W  autopush threshold; 0 means DATA_W
osr_threshold  input  CNT_W  autopull threshold; 0 means DATA_W
in_en  input  1  IN strobe
in_count  input  CNT_W  bits to shift in; 0 means DATA_W
in_data  input  DATA_W  IN source, LSB-aligned
out_en  input  1  OUT strobe
out_count  input  CNT_W  bits to shift out; 0 means DATA_W
push_req  input  1  explicit PUSH
pull_req  input  1  explicit PULL
block  input  1  blocking flag for push_req/pull_req
x_in  input  DATA_W  X register; OSR source for non-blocking PULL on empty TX
rx_data  output  DATA_W  word to RX FIFO
rx_valid  output  1  RX write request
rx_ready  input  1  RX FIFO not full
tx_data  input  DATA_W  word from TX FIFO
tx_valid  input  1  TX FIFO not empty
tx_ready  output  1  TX pop request
out_data  output  DATA_W  OUT result, LSB-aligned, zero-extended
out_valid  output  1  one-cycle OUT result strobe
isr  output  DATA_W  ISR contents (for MOV)
osr  output  DATA_W  OSR contents
stall  output  1  machine must hold PC and suppress new ops
rx_drop  output  1  one-cycle pulse: non-blocking push discarded

Behaviour:
- Reset (async): ISR=0, OSR=0, isr_cnt=0, osr_cnt=DATA_W (empty), FSM=IDLE. All outputs are 0.
- restart: same values as reset, applied on the next clk edge.
- Transfers: a FIFO transfer occurs on a clk edge with penable=1 and valid&&ready. rx_valid/tx_ready are combinational from FSM state and strobes. They are only asserted while penable=1.
- Op priority when strobes coincide: pull_req > push_req > out_en > in_en. Lower-priority strobes are ignored, not queued.
- Strobes are only sampled in IDLE. The machine holds its strobes while stall=1.
- IN n: right: ISR={in_data[n-1:0],ISR[DATA_W-1:n]}. Left: ISR={ISR[DATA_W-n-1:0],in_data[n-1:0]}. isr_cnt=min(isr_cnt+n,DATA_W).
  - If auto_push and the new isr_cnt>=threshold, go to PUSH_WAIT on the next edge.
- PUSH_WAIT: rx_data=ISR, rx_valid=1, stall=1. On transfer: ISR=0, isr_cnt=0, return to IDLE.
- Explicit PUSH:
  - rx_ready=1: transfer in the same cycle, ISR cleared, latency 1 penable cycle, no stall.
  - rx_ready=0, block=1: enter PUSH_WAIT.
  - rx_ready=0, block=0: ISR and isr_cnt cleared, rx_drop pulses, no transfer.
- OUT n:
  - auto_pull and osr_cnt>=threshold: enter PULL_OUT (stall=1), complete the pull, then execute the OUT on the next penable cycle.
  - Otherwise: right: out_data=OSR[n-1:0], OSR>>=n. Left: out_data=OSR[DATA_W-1 -: n], OSR<<=n. osr_cnt=min(osr_cnt+n,DATA_W). out_valid=1 for one clk.
- Explicit PULL:
  - tx_valid=1: OSR=tx_data, osr_cnt=0.
  - tx_valid=0, block=1: PULL_WAIT (stall).
  - tx_valid=0, block=0: OSR=x_in, osr_cnt=0.
  - With auto_pull and osr_cnt<threshold, PULL is a no-op.
- PULL_WAIT/PULL_OUT: tx_ready=tx_valid. On transfer: OSR=tx_data, osr_cnt=0. PULL_WAIT then goes to IDLE; PULL_OUT goes to OUT_EXEC then IDLE.
- States: IDLE, PUSH_WAIT, PULL_WAIT, PULL_OUT, OUT_EXEC. stall=1 in every state except IDLE.
- Counts saturate at DATA_W and never wrap.
- Threshold changes take effect at the next evaluation.
- penable=0 freezes all state. Strobe outputs are held low.

Optional Feature:
Macro PIO_SHIFT_STALL_CNT_EN.
- Defined: adds output stall_cycles[15:0]. It counts penable cycles with stall=1, saturates at 16'hFFFF, and is cleared by reset/restart.
- Undefined: the port is absent and there is no counter logic.

Test Plan:
- DATA_W=32, right, IN 8 bits four times with 0x11,0x22,0x33,0x44, auto_push, threshold 0 -> rx_valid once with rx_data=0x44332211; ISR=0 afterwards.
- Left, PULL with tx_data=0xA5000000, then OUT 4 twice -> out_data=0xA then 0x5; osr_cnt=8.
- auto_pull threshold 16, TX empty, OUT 8 after 16 bits consumed -> stall=1 until tx_valid. Then pop, and out_data equals the low 8 bits of the new word (right shift).
- Blocking PUSH with rx_ready=0 for 5 penable cycles -> stall=1 for 5 cycles, transfer on the 6th, no rx_drop. Non-blocking PUSH with rx_ready=0 -> rx_drop pulse, ISR=0.
- Non-blocking PULL with TX empty, x_in=0xDEADBEEF -> OSR=0xDEADBEEF, osr_cnt=0, no tx_ready.
- Assert reset during PULL_OUT -> all outputs 0 immediately; osr_cnt=DATA_W after release. With PIO_SHIFT_STALL_CNT_EN defined, stall_cycles=0.
